csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Machine-mode CSR register file; responder to the decode stage's CSR control bundle
//  (read/write index, write enable, write source, write mode, ECALL/MRET).
//  Performs CSRRW/CSRRS/CSRRC read-modify-write, ECALL trap entry and MRET return.
//  Provides mtvec/mepc to the PC mux. Sits in EX, beside the ALU.
// PARAMETERS
//  XLEN          32        data width of every CSR
//  MTVEC_RESET   32'h0     mtvec value after reset
//  ECALL_CAUSE   32'd11    value written to mcause on ECALL (M-mode environment call)
// PORTS
//  clk              in   1     clock, all state updates on rising edge
//  rst              in   1     asynchronous, active-high reset
//  stall            in   1     pipeline hold; suppresses every state update except mcycle
//  csr_read_index   in   12    CSR address for rdata
//  csr_write_index  in   12    CSR address for write
//  csr_write        in   1     write enable
//  csr_write_source in   2     00: operand (wdata); 01: trap entry (pc_in); 1x: reserved, no write
//  csr_how          in   2     00 write, 01 set (old|wdata), 10 clear (old&~wdata), 11 no write
//  csr_wdata        in   XLEN  rs1 value
//  pc_in            in   XLEN  PC of instruction in EX
//  mret             in   1     MRET in EX
//  instr_retire     in   1     one instruction retires this cycle
//  csr_rdata        out  XLEN  combinational read of csr_read_index (old value)
//  csr_illegal      out  1     combinational: csr_write or read to unimplemented index
//  mie_out          out  1     mstatus.MIE
// BEHAVIOUR
//  - Implemented: mstatus 0x300 (bits MIE[3], MPIE[7] only, others read 0), mtvec 0x305,
//    mscratch 0x340, mepc 0x341 (bits[1:0] forced 0), mcause 0x342.
//  - Reset (async, immediate): mstatus=0, mtvec=MTVEC_RESET, mscratch=mepc=mcause=0;
//    outputs follow from these (mie_out=0); counters 0.
//  - Read: csr_rdata = current register value, zero-latency; unimplemented -> 0, csr_illegal=1.
//  - Read-during-write same index: csr_rdata returns pre-write value; new value visible next cycle.
//  - Operand write (source 00, csr_write=1, !stall): register <= f(old, wdata, csr_how) at edge.
//    Write to unimplemented index: no state change, csr_illegal=1.
//  - Trap entry (source 01, csr_write=1, !stall): mepc<=pc_in, mcause<=ECALL_CAUSE,
//    MPIE<=MIE, MIE<=0, all in one edge; csr_how ignored.
//  - mret & !stall: MIE<=MPIE, MPIE<=1; no other state change. mret with csr_write: both apply.
//  - stall=1: no CSR/trap/mret update; inputs re-presented next cycle, action occurs once.
//  - Reset mid-operation: pending write discarded; no partial update.
// CONFIGURATION
//  CSR_COUNTERS_EN defined: adds mcycle 0xB00 and minstret 0xB02 (XLEN, wrap to 0 at max).
//    mcycle +1 every cycle (including stall); minstret +1 when instr_retire & !stall.
//    Same-cycle CSR write to a counter wins over its increment.
//  Not defined: 0xB00/0xB02 unimplemented (read 0, csr_illegal=1), no counter logic.
// TESTING
//  Reset then read 0x305 -> MTVEC_RESET; read 0x341/0x342/0x300 -> 0; read 0x7C0 -> 0, illegal=1.
//  CSRRW 0x340 wdata=A5A5_0000, then CSRRS 0x0000_00FF, then CSRRC 0x0000_000F -> reads A5A5_00F0.
//  Set MIE (CSRRS 0x300,0x8); ECALL pc_in=0x0000_0124 -> mepc=0x124, mcause=11, mstatus=0x80.
//  MRET after previous -> mstatus=0x88; same-cycle read of 0x341 during write returns old value.
//  Write 0x340 with stall=1 for 3 cycles then stall=0 -> one update; rst pulse mid-write -> 0.
//  CSR_COUNTERS_EN: mcycle=FFFF_FFFF wraps to 0; write mcycle=5 same cycle as tick -> reads 5.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file that sits in EX beside the ALU.
//
// Handles the decode stage's CSR bundle: CSRRW/CSRRS/CSRRC read-modify-write,
// ECALL trap entry and MRET return. It also feeds mtvec/mepc to the PC mux.
//
// Implemented CSRs:
//   mstatus  0x300  only MIE[3] and MPIE[7] are stored; all other bits read 0
//   mtvec    0x305
//   mscratch 0x340
//   mepc     0x341  bits [1:0] are forced to 0
//   mcause   0x342
//
// Optional feature (macro CSR_COUNTERS_EN):
//   Adds mcycle 0xB00 and minstret 0xB02. Both are XLEN wide and wrap to 0.
//   mcycle counts every cycle, including stalls. minstret counts unstalled retires.
//   A same-cycle CSR write to a counter takes priority over its increment.
//   When the macro is undefined, 0xB00/0xB02 are unimplemented.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   stall             pipeline hold; blocks every update except mcycle
//   csr_read_index    address for csr_rdata
//   csr_write_index   address for operand writes
//   csr_write         write enable
//   csr_write_source  00 operand, 01 trap entry (pc_in), 1x reserved (no write)
//   csr_how           00 write, 01 set, 10 clear, 11 no write
//   csr_wdata         rs1 value
//   pc_in             PC of the instruction in EX
//   mret              MRET in EX
//   instr_retire      an instruction retires this cycle
//   csr_rdata         combinational read, returns the pre-write value
//   csr_illegal       read index unimplemented, or operand write to an unimplemented index
//   mie_out           mstatus.MIE
//   mtvec_o, mepc_o   trap vector and return address for the PC mux
module csr_file #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [11:0]     csr_read_index,
  input  logic [11:0]     csr_write_index,
  input  logic            csr_write,
  input  logic [1:0]      csr_write_source,
  input  logic [1:0]      csr_how,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] pc_in,
  input  logic            mret,
  input  logic            instr_retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            mie_out,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] AddrMcycle   = 12'hB00;
  localparam logic [11:0] AddrMinstret = 12'hB02;
`endif

  localparam int unsigned MieBit  = 3;
  localparam int unsigned MpieBit = 7;

  localparam logic [1:0] SrcOperand = 2'b00;
  localparam logic [1:0] SrcTrap    = 2'b01;

  localparam logic [1:0] HowWrite = 2'b00;
  localparam logic [1:0] HowSet   = 2'b01;
  localparam logic [1:0] HowClear = 2'b10;
  localparam logic [1:0] HowNone  = 2'b11;

  // mepc always holds a 4-byte-aligned address.
  localparam logic [XLEN-1:0] MepcMask = ~XLEN'(3);

  // State
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
`endif

  logic [XLEN-1:0] mstatus_val;
  logic            rd_impl;
  logic            wr_impl;
  logic [XLEN-1:0] wr_old;
  logic [XLEN-1:0] wr_new;
  logic            op_wr_en;
  logic            trap_en;
  logic            mret_en;

  // mstatus assembled from its two stored bits.
  always_comb begin
    mstatus_val          = '0;
    mstatus_val[MieBit]  = mie_q;
    mstatus_val[MpieBit] = mpie_q;
  end

  // Read port. It is purely combinational, so a same-cycle write is not visible yet.
  always_comb begin
    rd_impl   = 1'b1;
    csr_rdata = '0;
    case (csr_read_index)
      AddrMstatus:  csr_rdata = mstatus_val;
      AddrMtvec:    csr_rdata = mtvec_q;
      AddrMscratch: csr_rdata = mscratch_q;
      AddrMepc:     csr_rdata = mepc_q;
      AddrMcause:   csr_rdata = mcause_q;
`ifdef CSR_COUNTERS_EN
      AddrMcycle:   csr_rdata = mcycle_q;
      AddrMinstret: csr_rdata = minstret_q;
`endif
      default:      rd_impl   = 1'b0;
    endcase
  end

  // Old value at the write index, used for set/clear.
  always_comb begin
    wr_impl = 1'b1;
    wr_old  = '0;
    case (csr_write_index)
      AddrMstatus:  wr_old  = mstatus_val;
      AddrMtvec:    wr_old  = mtvec_q;
      AddrMscratch: wr_old  = mscratch_q;
      AddrMepc:     wr_old  = mepc_q;
      AddrMcause:   wr_old  = mcause_q;
`ifdef CSR_COUNTERS_EN
      AddrMcycle:   wr_old  = mcycle_q;
      AddrMinstret: wr_old  = minstret_q;
`endif
      default:      wr_impl = 1'b0;
    endcase
  end

  always_comb begin
    wr_new = wr_old;
    case (csr_how)
      HowWrite: wr_new = csr_wdata;
      HowSet:   wr_new = wr_old | csr_wdata;
      HowClear: wr_new = wr_old & ~csr_wdata;
      default:  wr_new = wr_old;
    endcase
  end

  // Reserved write sources and csr_how=11 fall through as no-ops.
  assign op_wr_en = csr_write & (csr_write_source == SrcOperand) & (csr_how != HowNone) &
                    wr_impl & ~stall;
  assign trap_en  = csr_write & (csr_write_source == SrcTrap) & ~stall;
  assign mret_en  = mret & ~stall;

  assign csr_illegal = ~rd_impl |
                       (csr_write & (csr_write_source == SrcOperand) & ~wr_impl);

  // Next state. Order matters for mstatus: the operand write or trap entry is applied
  // first, and MRET then acts on that result.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    if (op_wr_en) begin
      case (csr_write_index)
        AddrMstatus: begin
          mie_d  = wr_new[MieBit];
          mpie_d = wr_new[MpieBit];
        end
        AddrMtvec:    mtvec_d    = wr_new;
        AddrMscratch: mscratch_d = wr_new;
        AddrMepc:     mepc_d     = wr_new & MepcMask;
        AddrMcause:   mcause_d   = wr_new;
        default:      ;
      endcase
    end

    if (trap_en) begin
      mepc_d   = pc_in & MepcMask;
      mcause_d = ECALL_CAUSE;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end

    if (mret_en) begin
      mie_d  = mpie_d;
      mpie_d = 1'b1;
    end
  end

`ifdef CSR_COUNTERS_EN
  // The increment runs first; a same-cycle CSR write then overrides it.
  always_comb begin
    mcycle_d   = mcycle_q + XLEN'(1);
    minstret_d = minstret_q + XLEN'(instr_retire & ~stall);
    if (op_wr_en && (csr_write_index == AddrMcycle)) begin
      mcycle_d = wr_new;
    end
    if (op_wr_en && (csr_write_index == AddrMinstret)) begin
      minstret_d = wr_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign mie_out = mie_q;
  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

  localparam logic [31:0] MtvecRst = 32'h8000_0100;
  localparam int          KMstatus = 32'h300;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [11:0] ridx;
  logic [11:0] widx;
  logic        wr;
  logic [1:0]  src;
  logic [1:0]  how;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        mret;
  logic        retire;
  logic [31:0] rdata;
  logic        ill;
  logic        mie;
  logic [31:0] mtvec_pc;
  logic [31:0] mepc_pc;

  int n_tests = 0;
  int n_fail  = 0;

  csr_file #(
    .XLEN        (32),
    .MTVEC_RESET (MtvecRst),
    .ECALL_CAUSE (32'd11)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .csr_read_index   (ridx),
    .csr_write_index  (widx),
    .csr_write        (wr),
    .csr_write_source (src),
    .csr_how          (how),
    .csr_wdata        (wdata),
    .pc_in            (pc),
    .mret             (mret),
    .instr_retire     (retire),
    .csr_rdata        (rdata),
    .csr_illegal      (ill),
    .mie_out          (mie),
    .mtvec_o          (mtvec_pc),
    .mepc_o           (mepc_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    stall = 1'b0; ridx = 12'h000; widx = 12'h000; wr = 1'b0; src = 2'b00;
    how = 2'b11; wdata = '0; pc = '0; mret = 1'b0; retire = 1'b0;
  endtask

  // Inputs change on the falling edge, so the next step starts there.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic        stall;
    logic [11:0] ridx;
    logic [11:0] widx;
    logic        wr;
    logic [1:0]  src;
    logic [1:0]  how;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        mret;
    logic [31:0] exp_rdata;
    logic        exp_ill;
    logic        exp_mie;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [11:0] r, input logic [11:0] w,
                              input logic we, input logic [1:0] s, input logic [1:0] h,
                              input logic [31:0] d, input logic [31:0] p, input logic mr,
                              input logic [31:0] er, input logic ei, input logic em);
    vec_t v;
    v.name = n; v.stall = 1'b0; v.ridx = r; v.widx = w; v.wr = we; v.src = s; v.how = h;
    v.wdata = d; v.pc = p; v.mret = mr; v.exp_rdata = er; v.exp_ill = ei; v.exp_mie = em;
    return v;
  endfunction

  // Reference model: one associative entry per implemented CSR.
  logic [31:0] mreg [int];

  function automatic logic [31:0] mread(input logic [11:0] idx);
    return mreg.exists(int'(idx)) ? mreg[int'(idx)] : 32'h0;
  endfunction

  function automatic logic [31:0] wmask(input logic [11:0] idx);
    if (idx == 12'h300) return 32'h0000_0088;
    if (idx == 12'h341) return 32'hFFFF_FFFC;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    mreg.delete();
    mreg[32'h300] = 32'h0;
    mreg[32'h305] = MtvecRst;
    mreg[32'h340] = 32'h0;
    mreg[32'h341] = 32'h0;
    mreg[32'h342] = 32'h0;
`ifdef CSR_COUNTERS_EN
    mreg[32'hB00] = 32'h0;
    mreg[32'hB02] = 32'h0;
`endif
  endtask

  task automatic model_edge();
    logic [31:0] old;
    logic [31:0] nv;
    old = mread(widx);
`ifdef CSR_COUNTERS_EN
    mreg[32'hB00] = mreg[32'hB00] + 32'd1;
    if (!stall && retire) mreg[32'hB02] = mreg[32'hB02] + 32'd1;
`endif
    if (!stall) begin
      if (wr && src == 2'b00 && how != 2'b11 && mreg.exists(int'(widx))) begin
        case (how)
          2'b00:   nv = wdata;
          2'b01:   nv = old | wdata;
          default: nv = old & ~wdata;
        endcase
        mreg[int'(widx)] = nv & wmask(widx);
      end
      if (wr && src == 2'b01) begin
        mreg[32'h341] = pc & 32'hFFFF_FFFC;
        mreg[32'h342] = 32'd11;
        mreg[KMstatus] = mreg[KMstatus][3] ? 32'h80 : 32'h0;
      end
      if (mret) mreg[KMstatus] = 32'h80 | (mreg[KMstatus][7] ? 32'h8 : 32'h0);
    end
  endtask

  function automatic logic [11:0] pick_idx();
    logic [11:0] t [9] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                           12'hB00, 12'hB02, 12'h7C0, 12'h001};
    int k = $urandom_range(0, 9);
    if (k == 9) return 12'($urandom);
    return t[k];
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mk("rst_mtvec",    12'h305, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, MtvecRst, 0, 0));
    vecs.push_back(mk("rst_mepc",     12'h341, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk("rst_mcause",   12'h342, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk("rst_mstatus",  12'h300, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk("rd_unimpl",    12'h7C0, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, 32'h0, 1, 0));
    vecs.push_back(mk("csrrw_scr",    12'h340, 12'h340, 1, 2'b00, 2'b00, 32'hA5A5_0000, 0, 0,
                      32'h0, 0, 0));
    vecs.push_back(mk("csrrs_scr",    12'h340, 12'h340, 1, 2'b00, 2'b01, 32'h0000_00FF, 0, 0,
                      32'hA5A5_0000, 0, 0));
    vecs.push_back(mk("csrrc_scr",    12'h340, 12'h340, 1, 2'b00, 2'b10, 32'h0000_000F, 0, 0,
                      32'hA5A5_00FF, 0, 0));
    vecs.push_back(mk("rd_scr",       12'h340, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0,
                      32'hA5A5_00F0, 0, 0));
    vecs.push_back(mk("set_mie",      12'h300, 12'h300, 1, 2'b00, 2'b01, 32'h8, 0, 0,
                      32'h0, 0, 0));
    vecs.push_back(mk("ecall",        12'h300, 12'h000, 1, 2'b01, 2'b11, 0, 32'h0000_0124, 0,
                      32'h8, 0, 1));
    vecs.push_back(mk("trap_mepc",    12'h341, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, 32'h124, 0, 0));
    vecs.push_back(mk("trap_mcause",  12'h342, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, 32'd11, 0, 0));
    vecs.push_back(mk("mret",         12'h300, 12'h000, 0, 2'b00, 2'b11, 0, 0, 1, 32'h80, 0, 0));
    vecs.push_back(mk("post_mret",    12'h300, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, 32'h88, 0, 1));
    vecs.push_back(mk("rdw_mepc",     12'h341, 12'h341, 1, 2'b00, 2'b00, 32'h203, 0, 0,
                      32'h124, 0, 1));
    vecs.push_back(mk("mepc_align",   12'h341, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, 32'h200, 0, 1));
    vecs.push_back(mk("mstatus_all",  12'h300, 12'h300, 1, 2'b00, 2'b00, 32'hFFFF_FFFF, 0, 0,
                      32'h88, 0, 1));
    vecs.push_back(mk("mstatus_mask", 12'h300, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, 32'h88, 0, 1));
    vecs.push_back(mk("wr_unimpl",    12'h300, 12'h7C0, 1, 2'b00, 2'b00, 32'h0, 0, 0,
                      32'h88, 1, 1));
    vecs.push_back(mk("src_rsvd",     12'h305, 12'h305, 1, 2'b10, 2'b00, 32'h1234, 0, 0,
                      MtvecRst, 0, 1));
    vecs.push_back(mk("rsvd_nochg",   12'h305, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, MtvecRst, 0, 1));
    vecs.push_back(mk("how_none",     12'h340, 12'h340, 1, 2'b00, 2'b11, 32'h0, 0, 0,
                      32'hA5A5_00F0, 0, 1));
    vecs.push_back(mk("how_nochg",    12'h340, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0,
                      32'hA5A5_00F0, 0, 1));
`ifndef CSR_COUNTERS_EN
    vecs.push_back(mk("no_mcycle",    12'hB00, 12'h000, 0, 2'b00, 2'b11, 0, 0, 0, 32'h0, 1, 1));
    vecs.push_back(mk("no_minstret",  12'hB02, 12'hB02, 1, 2'b00, 2'b00, 32'h7, 0, 0,
                      32'h0, 1, 1));
`endif

    foreach (vecs[i]) begin
      stall = vecs[i].stall; ridx = vecs[i].ridx; widx = vecs[i].widx; wr = vecs[i].wr;
      src = vecs[i].src; how = vecs[i].how; wdata = vecs[i].wdata; pc = vecs[i].pc;
      mret = vecs[i].mret;
      #1;
      check({vecs[i].name, "/rdata"}, rdata, vecs[i].exp_rdata);
      check({vecs[i].name, "/illegal"}, 32'(ill), 32'(vecs[i].exp_ill));
      check({vecs[i].name, "/mie"}, 32'(mie), 32'(vecs[i].exp_mie));
      tick();
    end
    idle();

    // A stalled MRET must take effect exactly once. A second application would
    // change mstatus from 0x80 to 0x88.
    ridx = 12'h300; widx = 12'h300; wr = 1'b1; how = 2'b00; wdata = 32'h0;
    tick();
    wr = 1'b0; mret = 1'b1; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check("stall_mret_hold", rdata, 32'h0);
      tick();
    end
    stall = 1'b0;
    #1 check("stall_mret_go", rdata, 32'h0);
    tick();
    mret = 1'b0;
    #1 check("stall_mret_once", rdata, 32'h80);

    // A stalled operand write must not land until the stall is released.
    ridx = 12'h340; widx = 12'h340; wr = 1'b1; how = 2'b00; wdata = 32'h1111_2222;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check("stall_wr_hold", rdata, 32'hA5A5_00F0);
      tick();
    end
    stall = 1'b0;
    tick();
    wr = 1'b0;
    #1 check("stall_wr_once", rdata, 32'h1111_2222);
    tick();

    // Raise reset in the middle of a write. It clears state immediately and the
    // pending write is discarded.
    ridx = 12'h340; widx = 12'h340; wr = 1'b1; how = 2'b00; wdata = 32'hDEAD_BEEF;
    #2 rst = 1'b1;
    #1 check("async_rst_scr", rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr = 1'b0;
    #1 check("rst_mid_scr", rdata, 32'h0);
    ridx = 12'h305;
    #1 check("rst_mid_mtvec", rdata, MtvecRst);
    check("rst_mid_mtvec_o", mtvec_pc, MtvecRst);
    check("rst_mid_mie", 32'(mie), 32'h0);
    tick();

`ifdef CSR_COUNTERS_EN
    // mcycle wraps from all-ones to 0. A write in the same cycle as an increment wins.
    idle();
    widx = 12'hB00; wr = 1'b1; how = 2'b00; wdata = 32'hFFFF_FFFF;
    tick();
    wr = 1'b0; ridx = 12'hB00;
    #1 check("mcycle_max", rdata, 32'hFFFF_FFFF);
    tick();
    #1 check("mcycle_wrap", rdata, 32'h0);
    wr = 1'b1; wdata = 32'd5;
    tick();
    wr = 1'b0;
    #1 check("mcycle_wr_wins", rdata, 32'd5);
    tick();
`endif

    // Randomized phase, compared against the model.
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      logic [31:0] exp_r;
      logic        exp_i;
      stall  = ($urandom_range(0, 3) == 0);
      ridx   = pick_idx();
      widx   = pick_idx();
      wr     = 1'($urandom_range(0, 1));
      src    = ($urandom_range(0, 5) < 4) ? 2'b00 : 2'($urandom_range(1, 3));
      how    = 2'($urandom_range(0, 3));
      wdata  = $urandom;
      pc     = $urandom;
      mret   = ($urandom_range(0, 7) == 0);
      retire = 1'($urandom_range(0, 1));
      if (mret && widx == 12'h300) widx = 12'h340;
      if (mret && src == 2'b01) src = 2'b00;
      #1;
      exp_r = mread(ridx);
      exp_i = !mreg.exists(int'(ridx)) || (wr && src == 2'b00 && !mreg.exists(int'(widx)));
      check("rand_rdata", rdata, exp_r);
      check("rand_illegal", 32'(ill), 32'(exp_i));
      check("rand_mie", 32'(mie), 32'(mreg[KMstatus][3]));
      check("rand_mepc_o", mepc_pc, mreg[32'h341]);
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
